// File: rtl/dbus_responder_if.sv
// Data-bus bundle between the core (master) and the responder (slave).
// Carries the access strobes, address/width/store data and the load data,
// timer interrupt and sticky error flag back towards the core.
interface dbus_responder_if;
  logic [31:0] bus_address;
  logic [1:0]  bus_width;
  logic [31:0] bus_wdata;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        irq;
  logic        bus_error;

  modport master (
    output bus_address, bus_width, bus_wdata, bus_read, bus_write,
    input  bus_rdata, irq, bus_error
  );

  modport slave (
    input  bus_address, bus_width, bus_wdata, bus_read, bus_write,
    output bus_rdata, irq, bus_error
  );
endinterface

// File: rtl/dbus_responder.sv
// Data-bus responder: byte-addressable data RAM plus a 64-bit MMIO timer that raises irq.
// Latency: stores commit at the strobe edge; load data is registered one cycle after bus_read.
// No backpressure: every strobe completes in one cycle. Optional macro DBUS_TIMER_PRESCALE_EN adds a prescaler.
module dbus_responder #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  dbus_responder_if.slave   bus
);

  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  // MMIO register word indices inside the 64-byte window
  localparam logic [3:0] REG_TIME_LO = 4'h0;
  localparam logic [3:0] REG_TIME_HI = 4'h1;
  localparam logic [3:0] REG_CMP_LO  = 4'h2;
  localparam logic [3:0] REG_CMP_HI  = 4'h3;
  localparam logic [3:0] REG_CTRL    = 4'h4;
  localparam logic [3:0] REG_STATUS  = 4'h5;
  localparam logic [3:0] REG_PRESC   = 4'h6;

  // Data RAM, four byte lanes per word; contents survive reset
  logic [3:0][7:0] ram_q [RAM_WORDS];

  // Timer and bus state
  logic [63:0] cnt_q,   cnt_d;
  logic [63:0] cmp_q,   cmp_d;
  logic        en_q,    en_d;
  logic        pend_q,  pend_d;
  logic [31:0] snap_q,  snap_d;
  logic        irq_q,   irq_d;
  logic        err_q,   err_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef DBUS_TIMER_PRESCALE_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] pcnt_q,  pcnt_d;
`endif

  // Decode results
  logic        acc, misalign, in_ram, in_mmio, ram_sel, mmio_sel, acc_err;
  logic        rd_ok, wr_ok, ram_we, mmio_we;
  logic [1:0]  off;
  logic [31:0] ram_off, mmio_off;
  logic [3:0]  reg_idx;
  logic [IDX_W-1:0] ram_idx;

  // Lane steering
  logic [3:0]  be;
  logic [31:0] wlane, ram_word, ram_rd, mmio_rd;
  logic        tick;

  // Classify the access: region, alignment and every error cause
  always_comb begin
    acc      = bus.bus_read | bus.bus_write;
    off      = bus.bus_address[1:0];
    ram_off  = bus.bus_address - RAM_BASE;
    mmio_off = bus.bus_address - MMIO_BASE;
    // Offsets wrap below the base, so one unsigned compare covers both bounds
    in_ram   = ram_off < RAM_BYTES;
    in_mmio  = mmio_off < 32'd64;
    ram_sel  = in_ram;
    mmio_sel = !in_ram && in_mmio;
    reg_idx  = mmio_off[5:2];
    ram_idx  = ram_off[IDX_W+1:2];
    misalign = ((bus.bus_width == 2'd1) && off[0]) ||
               ((bus.bus_width == 2'd2) && (off != 2'd0));
    acc_err  = acc && ((bus.bus_read && bus.bus_write) ||
                       (bus.bus_width == 2'd3) ||
                       misalign ||
                       !(ram_sel || mmio_sel) ||
                       (mmio_sel && (bus.bus_width != 2'd2)));
    rd_ok    = bus.bus_read  && !acc_err;
    wr_ok    = bus.bus_write && !acc_err;
    ram_we   = wr_ok && ram_sel;
    mmio_we  = wr_ok && mmio_sel;
  end

  // Byte enables and lane placement for stores, lane extraction for loads
  always_comb begin
    be       = 4'b0000;
    wlane    = bus.bus_wdata;
    ram_word = ram_q[ram_idx];
    ram_rd   = 32'd0;
    case (bus.bus_width)
      2'd0: begin
        be     = 4'b0001 << off;
        wlane  = {4{bus.bus_wdata[7:0]}};
        ram_rd = {24'd0, ram_word[{off, 3'b000} +: 8]};
      end
      2'd1: begin
        be     = off[1] ? 4'b1100 : 4'b0011;
        wlane  = {2{bus.bus_wdata[15:0]}};
        ram_rd = {16'd0, (off[1] ? ram_word[31:16] : ram_word[15:0])};
      end
      2'd2: begin
        be     = 4'b1111;
        wlane  = bus.bus_wdata;
        ram_rd = ram_word;
      end
      default: begin
        be     = 4'b0000;
        wlane  = bus.bus_wdata;
        ram_rd = 32'd0;
      end
    endcase
  end

  // MMIO read multiplexer; unused offsets read as zero
  always_comb begin
    mmio_rd = 32'd0;
    case (reg_idx)
      REG_TIME_LO: mmio_rd = cnt_q[31:0];
      REG_TIME_HI: mmio_rd = snap_q;
      REG_CMP_LO:  mmio_rd = cmp_q[31:0];
      REG_CMP_HI:  mmio_rd = cmp_q[63:32];
      REG_CTRL:    mmio_rd = {30'd0, pend_q, en_q};
      REG_STATUS:  mmio_rd = {31'd0, err_q};
`ifdef DBUS_TIMER_PRESCALE_EN
      REG_PRESC:   mmio_rd = {16'd0, presc_q};
`endif
      default:     mmio_rd = 32'd0;
    endcase
  end

  // Timer, register writes, error flag and load data next-state
  always_comb begin
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    en_d    = en_q;
    pend_d  = pend_q;
    snap_d  = snap_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    irq_d   = en_q & pend_q;
`ifdef DBUS_TIMER_PRESCALE_EN
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    tick    = en_q && (pcnt_q == presc_q);
    if (en_q) pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
`else
    tick    = en_q;
`endif

    if (tick) cnt_d = cnt_q + 64'd1;
    if (en_q && (cnt_q >= cmp_q)) pend_d = 1'b1;

    // A register write is applied after the increment so it wins
    if (mmio_we) begin
      case (reg_idx)
        REG_TIME_LO: cnt_d = {cnt_q[63:32], bus.bus_wdata};
        REG_TIME_HI: cnt_d = {bus.bus_wdata, cnt_q[31:0]};
        REG_CMP_LO:  cmp_d[31:0]  = bus.bus_wdata;
        REG_CMP_HI:  cmp_d[63:32] = bus.bus_wdata;
        REG_CTRL: begin
          en_d = bus.bus_wdata[0];
          if (bus.bus_wdata[1]) pend_d = 1'b0;
        end
        REG_STATUS: begin
          if (bus.bus_wdata[0]) err_d = 1'b0;
        end
`ifdef DBUS_TIMER_PRESCALE_EN
        REG_PRESC: begin
          presc_d = bus.bus_wdata[15:0];
          pcnt_d  = 16'd0;
        end
`endif
        default: ;
      endcase
    end

    // Reading TIME_LO freezes the upper half for a tear-free TIME_HI read
    if (rd_ok && mmio_sel && (reg_idx == REG_TIME_LO)) snap_d = cnt_q[63:32];

    // Error set takes priority over a same-cycle clear
    if (acc_err) err_d = 1'b1;

    if (bus.bus_read) rdata_d = rd_ok ? (ram_sel ? ram_rd : mmio_rd) : 32'd0;
  end

  // RAM byte-lane writes
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram_q[ram_idx][i] <= wlane[i*8 +: 8];
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= 64'd0;
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q    <= 1'b0;
      pend_q  <= 1'b0;
      snap_q  <= 32'd0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
`ifdef DBUS_TIMER_PRESCALE_EN
      presc_q <= 16'd0;
      pcnt_q  <= 16'd0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      snap_q  <= snap_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef DBUS_TIMER_PRESCALE_EN
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
`endif
    end
  end

  assign bus.bus_rdata = rdata_q;
  assign bus.irq       = irq_q;
  assign bus.bus_error = err_q;

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: directed table, multi-cycle timer/reset sequences,
// then randomized accesses checked against a transaction-level reference model.
module tb_dbus_responder;

  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dbus_responder_if bus_if();

  dbus_responder #(
    .RAM_WORDS(RAM_WORDS),
    .RAM_BASE (RAM_BASE),
    .MMIO_BASE(MMIO_BASE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model state
  logic [7:0]  ref_mem [0:4*RAM_WORDS-1];
  logic [63:0] m_cnt, m_cmp;
  logic        m_en, m_pend, m_irq, m_err;
  logic [31:0] m_rdata, m_snap;
  logic [15:0] m_presc, m_pcnt;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  wid;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en = 0; m_pend = 0; m_irq = 0; m_err = 0;
    m_rdata = 32'd0; m_snap = 32'd0; m_presc = 16'd0; m_pcnt = 16'd0;
  endtask

  // One clock edge of the responder described as a bus transaction
  task automatic model_edge(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [1:0] w, input logic [31:0] d);
    logic [63:0] n_cnt, n_cmp, a64;
    logic        n_en, n_pend, n_irq, n_err, in_ram, in_mmio, bad, tick;
    logic [31:0] n_rdata, n_snap, o;
    logic [15:0] n_presc, n_pcnt;
    int          size, base;
    a64     = {32'd0, a};
    in_ram  = (a64 >= {32'd0, RAM_BASE}) && (a64 < {32'd0, RAM_BASE} + 64'(4*RAM_WORDS));
    in_mmio = !in_ram && (a64 >= {32'd0, MMIO_BASE}) && (a64 < {32'd0, MMIO_BASE} + 64'd64);
    size    = (w == 2'd3) ? 1 : (1 << w);
    bad     = (rd && wr) || (w == 2'd3) || ((a % size) != 0) ||
              !(in_ram || in_mmio) || (in_mmio && w != 2'd2);
`ifdef DBUS_TIMER_PRESCALE_EN
    tick   = m_en && (m_pcnt == m_presc);
    n_pcnt = m_en ? (tick ? 16'd0 : m_pcnt + 16'd1) : m_pcnt;
`else
    tick   = m_en;
    n_pcnt = m_pcnt;
`endif
    n_cnt = m_cnt + (tick ? 64'd1 : 64'd0);
    n_cmp = m_cmp; n_en = m_en; n_snap = m_snap; n_presc = m_presc;
    n_pend = m_pend | (m_en && (m_cnt >= m_cmp));
    n_irq  = m_en & m_pend;
    n_err  = m_err;
    n_rdata = m_rdata;
    if ((rd || wr) && bad) begin
      n_err = 1'b1;
      if (rd) n_rdata = 32'd0;
    end else if (in_ram && (rd || wr)) begin
      base = int'(a - RAM_BASE);
      if (wr) for (int i = 0; i < size; i++) ref_mem[base+i] = d[8*i +: 8];
      if (rd) begin
        n_rdata = 32'd0;
        for (int i = 0; i < size; i++) n_rdata[8*i +: 8] = ref_mem[base+i];
      end
    end else if (in_mmio && (rd || wr)) begin
      o = a - MMIO_BASE;
      if (wr) begin
        case (o)
          32'h00: n_cnt = {m_cnt[63:32], d};
          32'h04: n_cnt = {d, m_cnt[31:0]};
          32'h08: n_cmp[31:0] = d;
          32'h0C: n_cmp[63:32] = d;
          32'h10: begin n_en = d[0]; if (d[1]) n_pend = 1'b0; end
          32'h14: if (d[0]) n_err = 1'b0;
`ifdef DBUS_TIMER_PRESCALE_EN
          32'h18: begin n_presc = d[15:0]; n_pcnt = 16'd0; end
`endif
          default: ;
        endcase
      end
      if (rd) begin
        case (o)
          32'h00: begin n_rdata = m_cnt[31:0]; n_snap = m_cnt[63:32]; end
          32'h04: n_rdata = m_snap;
          32'h08: n_rdata = m_cmp[31:0];
          32'h0C: n_rdata = m_cmp[63:32];
          32'h10: n_rdata = {30'd0, m_pend, m_en};
          32'h14: n_rdata = {31'd0, m_err};
`ifdef DBUS_TIMER_PRESCALE_EN
          32'h18: n_rdata = {16'd0, m_presc};
`endif
          default: n_rdata = 32'd0;
        endcase
      end
    end
    m_cnt = n_cnt; m_cmp = n_cmp; m_en = n_en; m_pend = n_pend; m_irq = n_irq;
    m_err = n_err; m_rdata = n_rdata; m_snap = n_snap; m_presc = n_presc; m_pcnt = n_pcnt;
  endtask

  // Drive one bus cycle, advance the model, compare all outputs after the edge
  task automatic step(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [1:0] w, input logic [31:0] d);
    @(negedge clock);
    bus_if.bus_read    = rd;
    bus_if.bus_write   = wr;
    bus_if.bus_address = a;
    bus_if.bus_width   = w;
    bus_if.bus_wdata   = d;
    model_edge(rd, wr, a, w, d);
    @(posedge clock);
    #1;
    check({nm, " rdata"}, 64'(bus_if.bus_rdata), 64'(m_rdata));
    check({nm, " irq"},   64'(bus_if.irq),       64'(m_irq));
    check({nm, " error"}, 64'(bus_if.bus_error), 64'(m_err));
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 1'b0, 32'd0, 2'd2, 32'd0);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [1:0] w, input logic [31:0] d,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wid = w; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic rand_step();
    int          r, k;
    logic        rd, wr;
    logic [31:0] a, d;
    logic [1:0]  w;
    r = $urandom_range(0, 9);
    k = $urandom_range(0, 19);
    rd = (k == 0) || (k < 10);
    wr = (k == 0) || (k >= 10);
    d  = $urandom;
    w  = 2'($urandom_range(0, 3));
    if (r < 6) begin
      a = 32'($urandom_range(0, 63));
    end else if (r < 8) begin
      a = MMIO_BASE + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) w = 2'd2;
    end else if (r == 8) begin
      a = 32'h0000_1000 + 32'($urandom_range(0, 255));
    end else begin
      a = $urandom | 32'h4000_0000;
    end
    step("rand", rd, wr, a, w, d);
  endtask

  initial begin
    bus_if.bus_read    = 1'b0;
    bus_if.bus_write   = 1'b0;
    bus_if.bus_address = 32'd0;
    bus_if.bus_width   = 2'd2;
    bus_if.bus_wdata   = 32'd0;
    model_reset();

    // Reset state
    #12;
    check("reset rdata", 64'(bus_if.bus_rdata), 64'd0);
    check("reset irq",   64'(bus_if.irq),       64'd0);
    check("reset error", 64'(bus_if.bus_error), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Give the low 64 bytes of RAM known contents
    for (int i = 0; i < 16; i++) step("init", 1'b0, 1'b1, 32'(i*4), 2'd2, $urandom);

    // Directed table: lanes, merges, errors, boundaries, MMIO decode
    tbl.push_back(mk(0, 1, 32'h10, 2, 32'hDEADBEEF, 32'h0000_0000, 0));
    tbl.push_back(mk(1, 0, 32'h10, 0, 32'h0,        32'h0000_00EF, 0));
    tbl.push_back(mk(1, 0, 32'h11, 0, 32'h0,        32'h0000_00BE, 0));
    tbl.push_back(mk(1, 0, 32'h12, 0, 32'h0,        32'h0000_00AD, 0));
    tbl.push_back(mk(1, 0, 32'h13, 0, 32'h0,        32'h0000_00DE, 0));
    tbl.push_back(mk(1, 0, 32'h12, 1, 32'h0,        32'h0000_DEAD, 0));
    tbl.push_back(mk(0, 1, 32'h20, 2, 32'h11223344, 32'h0000_DEAD, 0));
    tbl.push_back(mk(0, 1, 32'h21, 0, 32'h0000005A, 32'h0000_DEAD, 0));
    tbl.push_back(mk(1, 0, 32'h20, 2, 32'h0,        32'h11225A44, 0));
    tbl.push_back(mk(0, 1, 32'h22, 1, 32'h0000CAFE, 32'h11225A44, 0));
    tbl.push_back(mk(1, 0, 32'h20, 2, 32'h0,        32'hCAFE5A44, 0));
    tbl.push_back(mk(0, 1, 32'h40, 2, 32'h01020304, 32'hCAFE5A44, 0));
    tbl.push_back(mk(1, 0, 32'h23, 1, 32'h0,        32'h0000_0000, 1));
    tbl.push_back(mk(0, 1, 32'h42, 2, 32'h99999999, 32'h0000_0000, 1));
    tbl.push_back(mk(1, 0, 32'h40, 2, 32'h0,        32'h01020304, 1));
    tbl.push_back(mk(0, 1, MMIO_BASE+32'h14, 2, 32'h1, 32'h01020304, 0));
    tbl.push_back(mk(1, 0, 32'h04, 3, 32'h0,        32'h0000_0000, 1));
    tbl.push_back(mk(0, 1, MMIO_BASE+32'h14, 2, 32'h1, 32'h0000_0000, 0));
    tbl.push_back(mk(1, 1, 32'h20, 2, 32'h55555555, 32'h0000_0000, 1));
    tbl.push_back(mk(0, 1, MMIO_BASE+32'h14, 2, 32'h1, 32'h0000_0000, 0));
    tbl.push_back(mk(1, 0, 32'h1000, 2, 32'h0,      32'h0000_0000, 1));
    tbl.push_back(mk(0, 1, 32'hFFC, 2, 32'hAABBCCDD, 32'h0000_0000, 1));
    tbl.push_back(mk(1, 0, 32'hFFC, 2, 32'h0,       32'hAABBCCDD, 1));
    tbl.push_back(mk(1, 0, MMIO_BASE+32'h14, 0, 32'h0, 32'h0000_0000, 1));
    tbl.push_back(mk(1, 0, MMIO_BASE+32'h14, 2, 32'h0, 32'h0000_0001, 1));
    tbl.push_back(mk(0, 1, MMIO_BASE+32'h14, 2, 32'h1, 32'h0000_0001, 0));
    tbl.push_back(mk(1, 0, MMIO_BASE+32'h30, 2, 32'h0, 32'h0000_0000, 0));
    tbl.push_back(mk(1, 0, MMIO_BASE+32'h40, 2, 32'h0, 32'h0000_0000, 1));
    tbl.push_back(mk(0, 1, MMIO_BASE+32'h14, 2, 32'h1, 32'h0000_0000, 0));
    tbl.push_back(mk(1, 0, 32'h20, 2, 32'h0,        32'hCAFE5A44, 0));
    tbl.push_back(mk(1, 0, MMIO_BASE+32'h10, 2, 32'h0, 32'h0000_0000, 0));

    foreach (tbl[i]) begin
      step($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wid, tbl[i].wdata);
      check($sformatf("tbl%0d const rdata", i), 64'(bus_if.bus_rdata), 64'(tbl[i].exp_rdata));
      check($sformatf("tbl%0d const error", i), 64'(bus_if.bus_error), 64'(tbl[i].exp_err));
    end

    // Compare match, irq delay, W1C re-assert, disable keeps pending
    step("cmplo",  0, 1, MMIO_BASE+32'h08, 2, 32'd5);
    step("cmphi",  0, 1, MMIO_BASE+32'h0C, 2, 32'd0);
    step("timelo", 0, 1, MMIO_BASE+32'h00, 2, 32'd0);
    step("timehi", 0, 1, MMIO_BASE+32'h04, 2, 32'd0);
    step("enable", 0, 1, MMIO_BASE+32'h10, 2, 32'd1);
    for (int i = 0; i < 5; i++) idle("run");
    step("ctrl6", 1, 0, MMIO_BASE+32'h10, 2, 32'd0);
    check("ctrl6 pend clear", 64'(bus_if.bus_rdata), 64'd1);
    check("ctrl6 irq low",    64'(bus_if.irq),       64'd0);
    step("ctrl7", 1, 0, MMIO_BASE+32'h10, 2, 32'd0);
    check("ctrl7 pend set",   64'(bus_if.bus_rdata), 64'd3);
    check("ctrl7 irq high",   64'(bus_if.irq),       64'd1);
    step("w1c",   0, 1, MMIO_BASE+32'h10, 2, 32'd3);
    check("w1c irq held",     64'(bus_if.irq),       64'd1);
    step("ctrl9", 1, 0, MMIO_BASE+32'h10, 2, 32'd0);
    check("after w1c pend",   64'(bus_if.bus_rdata), 64'd1);
    step("ctrl10", 1, 0, MMIO_BASE+32'h10, 2, 32'd0);
    check("pend reasserted",  64'(bus_if.bus_rdata), 64'd3);
    step("disable", 0, 1, MMIO_BASE+32'h10, 2, 32'd0);
    check("disable irq edge", 64'(bus_if.irq),       64'd1);
    idle("dis_idle");
    check("disable irq drop", 64'(bus_if.irq),       64'd0);
    step("ctrl13", 1, 0, MMIO_BASE+32'h10, 2, 32'd0);
    check("pend kept",        64'(bus_if.bus_rdata), 64'd2);

    // Carry across 32 bits and tear-free LO/HI read
    step("tlo", 0, 1, MMIO_BASE+32'h00, 2, 32'hFFFF_FFFF);
    step("thi", 0, 1, MMIO_BASE+32'h04, 2, 32'h0);
    step("en2", 0, 1, MMIO_BASE+32'h10, 2, 32'd1);
    idle("carry1");
    idle("carry2");
    step("rdlo", 1, 0, MMIO_BASE+32'h00, 2, 32'h0);
    check("time lo", 64'(bus_if.bus_rdata), 64'd1);
    step("rdhi", 1, 0, MMIO_BASE+32'h04, 2, 32'h0);
    check("time hi", 64'(bus_if.bus_rdata), 64'd1);

    // Reset during a load: outputs clear at once, RAM survives
    step("st30", 0, 1, 32'h30, 2, 32'h12345678);
    step("ld30", 1, 0, 32'h30, 2, 32'h0);
    check("pre-reset irq", 64'(bus_if.irq), 64'd1);
    bus_if.bus_read = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst rdata", 64'(bus_if.bus_rdata), 64'd0);
    check("midrst irq",   64'(bus_if.irq),       64'd0);
    check("midrst error", 64'(bus_if.bus_error), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    step("ld30b", 1, 0, 32'h30, 2, 32'h0);
    check("ram survives reset", 64'(bus_if.bus_rdata), 64'h12345678);
    step("ctrl_rst", 1, 0, MMIO_BASE+32'h10, 2, 32'h0);
    check("ctrl after reset", 64'(bus_if.bus_rdata), 64'd0);

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
